wiegand_rx: RTL

Parametrised Wiegand reader receiver that accepts variable-length frames, up to MAX_BITS, from a two-wire D0/D1 interface.
- Inputs are synchronised and glitch-filtered.
- The end of a frame is detected by an inter-pulse timeout.
- Leading/trailing parity is checked on even-length frames.
- Each completed frame is presented on a valid/ack handshake to the host-side register block, with an active-low interrupt.

---
 rtl/wiegand_pkg.sv | 41 ++++
 rtl/wiegand_rx_filt.sv | 43 ++++
 rtl/wiegand_rx.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/wiegand_pkg.sv
// Shared types and helpers for the Wiegand receiver: FSM states, width helper
// and the leading-even / trailing-odd parity evaluation.
package wiegand_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int W26 = 26;
    localparam int W34 = 34;

    // Parity helper works on a fixed-width view; callers zero-extend into it.
    localparam int PAR_W  = 64;
    localparam int PAR_LW = 7;

    function automatic int lw_f(input int max_bits);
        return $clog2(max_bits + 1);
    endfunction

    // Upper half (first received) must XOR to 0, lower half must XOR to 1.
    // Odd or zero lengths never flag an error.
    function automatic logic parity_err_f(input logic [PAR_W-1:0]  data,
                                          input logic [PAR_LW-1:0] len);
        logic [PAR_LW-1:0] half;
        logic              x_hi;
        logic              x_lo;
        half = len >> 1;
        x_hi = 1'b0;
        x_lo = 1'b0;
        for (int i = 0; i < PAR_W; i++) begin
            if (PAR_LW'(i) < len) begin
                if (PAR_LW'(i) >= half) x_hi = x_hi ^ data[i];
                else                    x_lo = x_lo ^ data[i];
            end
        end
        return ~len[0] & (len != '0) & (x_hi | ~x_lo);
    endfunction

endpackage

// File: rtl/wiegand_rx_filt.sv
// One Wiegand line: 2-flop synchroniser followed by a FILT_CYC-sample
// persistence filter. Everything resets to the idle (high) level.
module wiegand_filt
    import wiegand_pkg::*;
#(
    parameter int FILT_CYC = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic line_o
);

    localparam int FW = $clog2(FILT_CYC + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          filt_q;
    logic [FW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            if (sync2_q == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == FW'(FILT_CYC - 1)) begin
                filt_q <= sync2_q;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + FW'(1);
            end
        end
    end

    assign line_o = filt_q;

endmodule

// File: rtl/wiegand_rx.sv
// Wiegand D0/D1 frame receiver with timeout framing, parity check and a
// valid/ack host handshake.
//   state | meaning
//   IDLE  | waiting for the first bit edge (lines must have been high since any fault)
//   RECV  | collecting bits, gap counter running between pulses
//   DONE  | one cycle: length check, load or drop the frame
module wiegand_rx
    import wiegand_pkg::*;
#(
    parameter int MAX_BITS     = W34,
    parameter int MIN_BITS     = 4,
    parameter int TIMEOUT_CYC  = 5000,
    parameter int FILT_CYC     = 4,
    parameter int CHECK_PARITY = 1,
    parameter int LW           = lw_f(MAX_BITS)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [1:0]          wigend_i,
    output logic [MAX_BITS-1:0] frame_data_o,
    output logic [LW-1:0]       frame_len_o,
    output logic                frame_valid_o,
    input  logic                frame_ack_i,
    output logic                parity_err_o,
    output logic                line_err_o,
    output logic                overrun_o,
    output logic                busy_o,
    output logic                int_n_o
);

    localparam int GW = $clog2(TIMEOUT_CYC + 1);
    localparam int CW = $clog2(MAX_BITS + 2);

    logic [1:0]          line_f;
    logic [1:0]          line_prev_q;
    logic                armed_q;
    state_e              state_q;
    logic [MAX_BITS-1:0] shift_q;
    logic [CW-1:0]       cnt_q;
    logic [GW-1:0]       gap_q;
    logic [MAX_BITS-1:0] data_q;
    logic [LW-1:0]       len_q;
    logic                valid_q;
    logic                perr_q;
    logic                lerr_q;
    logic                ovr_q;

    logic both_high;
    logic both_low;
    logic bit_evt;
    logic bit_val;
    logic par_now;
    logic ack_take;

    wiegand_filt #(.FILT_CYC(FILT_CYC)) u_filt_d0 (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .line_i (wigend_i[0]),
        .line_o (line_f[0])
    );

    wiegand_filt #(.FILT_CYC(FILT_CYC)) u_filt_d1 (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .line_i (wigend_i[1]),
        .line_o (line_f[1])
    );

    assign both_high = line_f[0] & line_f[1];
    assign both_low  = ~line_f[0] & ~line_f[1];
    assign bit_val   = line_prev_q[1] & ~line_f[1] & line_f[0];
    assign bit_evt   = (line_prev_q[0] & ~line_f[0] & line_f[1]) | bit_val;
    assign ack_take  = frame_ack_i & valid_q;
    assign par_now   = (CHECK_PARITY != 0) ?
                       parity_err_f(PAR_W'(shift_q), PAR_LW'(cnt_q)) : 1'b0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            line_prev_q <= 2'b11;
            armed_q     <= 1'b1;
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            data_q      <= '0;
            len_q       <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            lerr_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            line_prev_q <= line_f;

            if (both_high)     armed_q <= 1'b1;
            else if (both_low) armed_q <= 1'b0;

            if (!both_high || state_q != RECV)  gap_q <= '0;
            else if (gap_q != GW'(TIMEOUT_CYC)) gap_q <= gap_q + GW'(1);

            if (ack_take) begin
                valid_q <= 1'b0;
                ovr_q   <= 1'b0;
                lerr_q  <= 1'b0;
            end
            if (both_low) lerr_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (armed_q && bit_evt) begin
                        state_q <= RECV;
                        shift_q <= {{(MAX_BITS-1){1'b0}}, bit_val};
                        cnt_q   <= CW'(1);
                    end
                end
                RECV: begin
                    if (both_low) begin
                        state_q <= IDLE;
                        shift_q <= '0;
                        cnt_q   <= '0;
                    end else if (bit_evt) begin
                        if (cnt_q < CW'(MAX_BITS))  shift_q <= {shift_q[MAX_BITS-2:0], bit_val};
                        if (cnt_q <= CW'(MAX_BITS)) cnt_q <= cnt_q + CW'(1);
                    end else if (gap_q == GW'(TIMEOUT_CYC - 1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // An ack in this same cycle frees the slot for the new frame.
                    if (cnt_q < CW'(MIN_BITS) || cnt_q > CW'(MAX_BITS)) begin
                        if (cnt_q > CW'(MAX_BITS)) lerr_q <= 1'b1;
                    end else if (valid_q && !frame_ack_i) begin
                        ovr_q <= 1'b1;
                    end else begin
                        data_q  <= shift_q;
                        len_q   <= LW'(cnt_q);
                        perr_q  <= par_now;
                        valid_q <= 1'b1;
                    end
                    state_q <= IDLE;
                    shift_q <= '0;
                    cnt_q   <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign frame_data_o  = data_q;
    assign frame_len_o   = len_q;
    assign frame_valid_o = valid_q;
    assign parity_err_o  = perr_q;
    assign line_err_o    = lerr_q;
    assign overrun_o     = ovr_q;
    assign busy_o        = (state_q == RECV);
    assign int_n_o       = ~valid_q;

endmodule
